// File: rtl/wide_vector_processor.sv
// Wide vector datapath: 4 x 512-bit register file, 512-bit ALU,
// and a 512 x 32-bit data memory accessed 16 words at a time.
module wvp_regfile (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [1:0]   waddr_i,
    input  logic [511:0] wdata_i,
    input  logic [1:0]   raddr_a_i,
    input  logic [1:0]   raddr_b_i,
    output logic [511:0] A1,
    output logic [511:0] A2
);
    logic [511:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign A1 = regs_q[raddr_a_i];
    assign A2 = regs_q[raddr_b_i];
endmodule

module wvp_alu (
    input  logic [511:0] a_i,
    input  logic [511:0] b_i,
    input  logic [1:0]   op_i,
    output logic [255:0] least_sig,
    output logic [255:0] most_sig
);
    logic [511:0] r;

    always_comb begin
        r = '0;
        unique case (op_i)
            2'b00: r = a_i + b_i;
            // Only the low halves multiply; the product fills all 512 bits.
            2'b01: r = {256'b0, a_i[255:0]} * {256'b0, b_i[255:0]};
            2'b10: r = a_i - b_i;
            2'b11: r = a_i ^ b_i;
            default: r = '0;
        endcase
    end

    assign least_sig = r[255:0];
    assign most_sig  = r[511:256];
endmodule

module wide_vector_processor #(
    parameter int NUM_REGS  = 4,
    parameter int MEM_WORDS = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [8:0]   memmory_address,
    input  logic [1:0]   resister_a_address,
    input  logic [1:0]   register_b_address,
    input  logic [1:0]   register_address_to_write,
    input  logic [511:0] data_to_write,
    input  logic         write_enable,
    input  logic [1:0]   alu_opcode,
    input  logic         mem_write_enable,
    output logic [511:0] result,
    output logic [255:0] alu_least_sig,
    output logic [255:0] alu_most_sig
);
    logic [511:0] op_a;
    logic [511:0] op_b;
    logic [31:0]  mem_q [MEM_WORDS];

    wvp_regfile registerFile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (write_enable),
        .waddr_i   (register_address_to_write),
        .wdata_i   (data_to_write),
        .raddr_a_i (resister_a_address),
        .raddr_b_i (register_b_address),
        .A1        (op_a),
        .A2        (op_b)
    );

    wvp_alu alu (
        .a_i       (op_a),
        .b_i       (op_b),
        .op_i      (alu_opcode),
        .least_sig (alu_least_sig),
        .most_sig  (alu_most_sig)
    );

    // 9-bit address arithmetic gives the mod-512 wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_write_enable) begin
            for (int k = 0; k < 16; k++)
                mem_q[memmory_address + 9'(k)] <= data_to_write[32*k +: 32];
        end
    end

    always_comb begin
        result = '0;
        for (int k = 0; k < 16; k++)
            result[32*k +: 32] = mem_q[memmory_address + 9'(k)];
    end
endmodule

// File: tb/tb_wide_vector_processor.sv
// Directed-vector bench for wide_vector_processor.
module tb_wide_vector_processor;
    logic         clk;
    logic         rst_n;
    logic [8:0]   memmory_address;
    logic [1:0]   resister_a_address;
    logic [1:0]   register_b_address;
    logic [1:0]   register_address_to_write;
    logic [511:0] data_to_write;
    logic         write_enable;
    logic [1:0]   alu_opcode;
    logic         mem_write_enable;
    logic [511:0] result;
    logic [255:0] alu_least_sig;
    logic [255:0] alu_most_sig;

    int n_vec;
    int n_bad;

    wide_vector_processor dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .memmory_address           (memmory_address),
        .resister_a_address        (resister_a_address),
        .register_b_address        (register_b_address),
        .register_address_to_write (register_address_to_write),
        .data_to_write             (data_to_write),
        .write_enable              (write_enable),
        .alu_opcode                (alu_opcode),
        .mem_write_enable          (mem_write_enable),
        .result                    (result),
        .alu_least_sig             (alu_least_sig),
        .alu_most_sig              (alu_most_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [1:0] r, input logic [511:0] d);
        @(negedge clk);
        register_address_to_write = r;
        data_to_write = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
    endtask

    task automatic mwrite(input logic [8:0] a, input logic [511:0] d);
        @(negedge clk);
        memmory_address = a;
        data_to_write = d;
        mem_write_enable = 1'b1;
        @(posedge clk);
        #1 mem_write_enable = 1'b0;
    endtask

    task automatic alu_sel(input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] op);
        resister_a_address = a;
        register_b_address = b;
        alu_opcode = op;
        #1;
    endtask

    logic [511:0] ones;
    logic [511:0] pat_a;
    logic [511:0] pat_5;
    logic [511:0] ramp;
    logic [511:0] exp_v;

    initial begin
        n_vec = 0;
        n_bad = 0;
        ones  = '1;
        pat_a = {128{4'hA}};
        pat_5 = {128{4'h5}};
        for (int k = 0; k < 16; k++) ramp[32*k +: 32] = 32'(k);

        rst_n = 1'b0;
        memmory_address = '0;
        resister_a_address = 2'd0;
        register_b_address = 2'd1;
        register_address_to_write = '0;
        data_to_write = '0;
        write_enable = 1'b0;
        alu_opcode = 2'b00;
        mem_write_enable = 1'b0;
        #12;
        chk("rst_result", result, '0);
        chk("rst_alu", {alu_most_sig, alu_least_sig}, '0);
        rst_n = 1'b1;

        load(2'd0, 512'd5);
        load(2'd1, 512'd7);
        alu_sel(2'd0, 2'd1, 2'b00);
        chk("add_5_7", {alu_most_sig, alu_least_sig}, 512'd12);

        load(2'd0, 512'd1 << 255);
        load(2'd1, 512'd4);
        alu_sel(2'd0, 2'd1, 2'b01);
        chk("mul_lo", {256'd0, alu_least_sig}, '0);
        chk("mul_hi", {256'd0, alu_most_sig}, 512'd2);

        load(2'd1, (512'd1 << 256) + 512'd3);
        alu_sel(2'd0, 2'd1, 2'b01);
        chk("mul_ign_hi", {alu_most_sig, alu_least_sig},
            (512'd1 << 256) | (512'd1 << 255));

        load(2'd0, ones);
        load(2'd1, 512'd1);
        alu_sel(2'd0, 2'd1, 2'b00);
        chk("add_wrap", {alu_most_sig, alu_least_sig}, '0);
        alu_sel(2'd0, 2'd1, 2'b10);
        chk("sub_lo", {256'd0, alu_least_sig}, {256'd0, {255{1'b1}}, 1'b0});
        chk("sub_hi", {256'd0, alu_most_sig}, {256'd0, {256{1'b1}}});
        alu_sel(2'd0, 2'd1, 2'b11);
        chk("xor", {alu_most_sig, alu_least_sig}, {{511{1'b1}}, 1'b0});

        load(2'd0, '0);
        alu_sel(2'd0, 2'd1, 2'b10);
        chk("sub_under", {alu_most_sig, alu_least_sig}, ones);

        mwrite(9'd0, pat_a);
        chk("mem_wr0", result, pat_a);
        mwrite(9'd16, '0);
        chk("mem_wr16", result, '0);
        memmory_address = 9'd0;
        #1 chk("mem_keep0", result, pat_a);

        mwrite(9'd8, pat_5);
        memmory_address = 9'd0;
        #1 chk("mem_overlap", result, {pat_5[255:0], pat_a[255:0]});

        @(negedge clk);
        memmory_address = 9'd510;
        data_to_write = ramp;
        mem_write_enable = 1'b1;
        write_enable = 1'b1;
        register_address_to_write = 2'd3;
        @(posedge clk);
        #1 mem_write_enable = 1'b0;
        write_enable = 1'b0;
        chk("mem_wrap_rd", result, ramp);
        memmory_address = 9'd0;
        #1 chk("mem_wrap_w0", {480'd0, result[31:0]}, 512'd2);
        for (int k = 0; k < 14; k++) exp_v[32*k +: 32] = 32'(k + 2);
        exp_v[511:448] = {2{32'h55555555}};
        chk("mem_wrap_blk", result, exp_v);
        alu_sel(2'd3, 2'd1, 2'b00);
        chk("dual_wr_r3", dut.registerFile.A1, ramp);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_a", dut.registerFile.A1, '0);
        chk("rst2_b", dut.registerFile.A2, '0);
        chk("rst2_result", result, '0);
        chk("rst2_alu", {alu_most_sig, alu_least_sig}, '0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
